// File: rtl/hanoi_move_sequencer.sv
// Purpose : autonomous Towers of Hanoi solver; issues the optimal 2^N-1 move
//           sequence (rod 0 -> rod 2) as from_rod/to_rod/disk_id moves.
// Latency : first move presented 1 cycle after start; one move per clock when accepted.
// Backpr. : valid/ready; a presented move is held stable until move_ready, and pause
//           only stops the next move from being presented.
// Ports   : clk, rst (sync, active-low), start, pause, move_ready ->
//           move_valid, from_rod, to_rod, disk_id, move_count, busy, done.
module hanoi_move_sequencer #(
    parameter  int NUMBER_OF_RODS  = 3,
    parameter  int NUMBER_OF_DISKS = 3,
    localparam int RODS_LOG2       = $clog2(NUMBER_OF_RODS),
    localparam int CNT_W           = NUMBER_OF_DISKS,
    localparam int DISK_W          = $clog2(NUMBER_OF_DISKS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 move_ready,
    output logic                 move_valid,
    output logic [RODS_LOG2-1:0] from_rod,
    output logic [RODS_LOG2-1:0] to_rod,
    output logic [DISK_W-1:0]    disk_id,
    output logic [CNT_W-1:0]     move_count,
    output logic                 busy,
    output logic                 done
);

    generate
        if (NUMBER_OF_RODS != 3) begin : g_bad_rods
            $error("hanoi_move_sequencer: only NUMBER_OF_RODS = 3 is supported");
        end
        if (NUMBER_OF_DISKS < 1 || NUMBER_OF_DISKS > 16) begin : g_bad_disks
            $error("hanoi_move_sequencer: NUMBER_OF_DISKS must be in 1..16");
        end
    endgenerate

    localparam logic [CNT_W-1:0] K_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] K_LAST = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   ONE_W  = (CNT_W + 1)'(1);
    // With an even tower the plain formula lands on rod 1; swapping labels 1/2 fixes that.
    localparam bit               SWAP   = (NUMBER_OF_DISKS % 2) == 0;

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_PAUSED, S_DONE} state_t;

    state_t                 r_state, w_state_next;
    logic [CNT_W-1:0]       r_k, w_k_next;
    logic                   r_move_valid, w_valid_next;
    logic [RODS_LOG2-1:0]   r_from_rod, r_to_rod;
    logic [DISK_W-1:0]      r_disk_id;
    logic [CNT_W-1:0]       r_move_count, w_count_next;
    logic                   r_busy, w_busy_next;
    logic                   r_done, w_done_next;
    logic                   w_load;
    logic                   w_hs;
    logic [CNT_W-1:0]       w_km1;
    logic [RODS_LOG2-1:0]   w_from_next, w_to_next;
    logic [DISK_W-1:0]      w_disk_next;

    // mod 3 without a divider: bit i has weight 2^i mod 3 = 1 (even i) or 2 (odd i).
    function automatic logic [RODS_LOG2-1:0] f_mod3(input logic [CNT_W:0] v);
        logic [2:0] acc;
        acc = 3'd0;
        for (int i = 0; i <= CNT_W; i++) begin
            if (v[i]) begin
                acc = acc + (((i % 2) == 1) ? 3'd2 : 3'd1);
                if (acc >= 3'd3) acc = acc - 3'd3;
            end
        end
        return acc[RODS_LOG2-1:0];
    endfunction

    function automatic logic [RODS_LOG2-1:0] f_label(input logic [RODS_LOG2-1:0] r);
        if (SWAP && (r != '0)) return RODS_LOG2'(3) - r;
        return r;
    endfunction

    // Disk size = trailing zeros + 1; scanning down leaves the lowest set bit.
    function automatic logic [DISK_W-1:0] f_disk(input logic [CNT_W-1:0] v);
        logic [DISK_W-1:0] d;
        d = '0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            if (v[i]) d = DISK_W'(i + 1);
        end
        return d;
    endfunction

    assign w_hs        = r_move_valid & move_ready;
    assign w_km1       = w_k_next - K_ONE;
    assign w_from_next = f_label(f_mod3({1'b0, w_k_next & w_km1}));
    // The +1 is taken one bit wider so k = 2^N-1 does not wrap to zero.
    assign w_to_next   = f_label(f_mod3({1'b0, w_k_next | w_km1} + ONE_W));
    assign w_disk_next = f_disk(w_k_next);

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_load       = 1'b0;
        w_valid_next = r_move_valid;
        w_count_next = r_move_count;
        w_busy_next  = r_busy;
        w_done_next  = r_done;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_MOVE;
                    w_k_next     = K_ONE;
                    w_load       = 1'b1;
                    w_valid_next = 1'b1;
                    w_count_next = '0;
                    w_busy_next  = 1'b1;
                    w_done_next  = 1'b0;
                end
            end
            S_MOVE: begin
                if (w_hs) begin
                    w_count_next = r_move_count + K_ONE;
                    if (r_k == K_LAST) begin
                        w_state_next = S_DONE;
                        w_valid_next = 1'b0;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                    end else begin
                        // Next move is loaded even when pausing, so resume needs no recompute.
                        w_k_next = r_k + K_ONE;
                        w_load   = 1'b1;
                        if (pause) begin
                            w_state_next = S_PAUSED;
                            w_valid_next = 1'b0;
                        end else begin
                            w_valid_next = 1'b1;
                        end
                    end
                end
            end
            S_PAUSED: begin
                if (!pause) begin
                    w_state_next = S_MOVE;
                    w_valid_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_valid_next = 1'b0;
                w_busy_next  = 1'b0;
                w_done_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_k          <= '0;
            r_move_valid <= 1'b0;
            r_from_rod   <= '0;
            r_to_rod     <= '0;
            r_disk_id    <= '0;
            r_move_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_k          <= w_k_next;
            r_move_valid <= w_valid_next;
            r_move_count <= w_count_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            if (w_load) begin
                r_from_rod <= w_from_next;
                r_to_rod   <= w_to_next;
                r_disk_id  <= w_disk_next;
            end
        end
    end

    assign move_valid = r_move_valid;
    assign from_rod   = r_from_rod;
    assign to_rod     = r_to_rod;
    assign disk_id    = r_disk_id;
    assign move_count = r_move_count;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_hanoi_move_sequencer.sv
// Purpose : self-checking bench for hanoi_move_sequencer with N = 3, 2 and 1 instances.
// Latency : expected moves queued at start, compared on every accepted move.
// Backpr. : exercises move_ready stalls, pause, reset mid-solve and restart.
module tb_hanoi_move_sequencer;

    typedef struct {
        int f;
        int t;
        int d;
        int idx;
    } mv_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       start3 = 1'b0, pause3 = 1'b0, ready3 = 1'b1;
    logic       valid3, busy3, done3;
    logic [1:0] from3, to3, disk3;
    logic [2:0] count3;

    logic       start2 = 1'b0;
    logic       valid2, busy2, done2;
    logic [1:0] from2, to2, disk2;
    logic [1:0] count2;

    logic       start1 = 1'b0;
    logic       valid1, busy1, done1;
    logic [1:0] from1, to1;
    logic [0:0] disk1;
    logic [0:0] count1;

    mv_t q3[$];
    mv_t q2[$];
    mv_t q1[$];
    mv_t m3, m2, m1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hanoi_move_sequencer #(.NUMBER_OF_RODS(3), .NUMBER_OF_DISKS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .pause(pause3), .move_ready(ready3),
        .move_valid(valid3), .from_rod(from3), .to_rod(to3), .disk_id(disk3),
        .move_count(count3), .busy(busy3), .done(done3));

    hanoi_move_sequencer #(.NUMBER_OF_RODS(3), .NUMBER_OF_DISKS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .pause(1'b0), .move_ready(1'b1),
        .move_valid(valid2), .from_rod(from2), .to_rod(to2), .disk_id(disk2),
        .move_count(count2), .busy(busy2), .done(done2));

    hanoi_move_sequencer #(.NUMBER_OF_RODS(3), .NUMBER_OF_DISKS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .pause(1'b0), .move_ready(1'b1),
        .move_valid(valid1), .from_rod(from1), .to_rod(to1), .disk_id(disk1),
        .move_count(count1), .busy(busy1), .done(done1));

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference sequences, straight from the known optimal solutions.
    task automatic push3();
        int fr[7] = '{0, 0, 2, 0, 1, 1, 0};
        int tr[7] = '{2, 1, 1, 2, 0, 2, 2};
        int dk[7] = '{1, 2, 1, 3, 1, 2, 1};
        for (int i = 0; i < 7; i++) q3.push_back('{fr[i], tr[i], dk[i], i + 1});
    endtask

    task automatic push2();
        q2.push_back('{0, 1, 1, 1});
        q2.push_back('{0, 2, 2, 2});
        q2.push_back('{1, 2, 1, 3});
    endtask

    task automatic push1();
        q1.push_back('{0, 2, 1, 1});
    endtask

    task automatic start_n3();
        push3();
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
    endtask

    task automatic wait_count3(input int target, input string tag);
        int c = 0;
        while (int'(count3) != target && c < 60) begin
            tick();
            c++;
        end
        chk(tag, int'(count3), target);
    endtask

    // Scoreboard monitors: compare every accepted move against the queue head.
    always @(negedge clk) begin
        if (rst && valid3 && ready3) begin
            if (q3.size() == 0) chk("n3_unexpected_move", 1, 0);
            else begin
                m3 = q3.pop_front();
                chk("n3_from", int'(from3), m3.f);
                chk("n3_to", int'(to3), m3.t);
                chk("n3_disk", int'(disk3), m3.d);
                chk("n3_count_at_accept", int'(count3), m3.idx - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && valid2) begin
            if (q2.size() == 0) chk("n2_unexpected_move", 1, 0);
            else begin
                m2 = q2.pop_front();
                chk("n2_from", int'(from2), m2.f);
                chk("n2_to", int'(to2), m2.t);
                chk("n2_disk", int'(disk2), m2.d);
                chk("n2_count_at_accept", int'(count2), m2.idx - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst && valid1) begin
            if (q1.size() == 0) chk("n1_unexpected_move", 1, 0);
            else begin
                m1 = q1.pop_front();
                chk("n1_from", int'(from1), m1.f);
                chk("n1_to", int'(to1), m1.t);
                chk("n1_disk", int'(disk1), m1.d);
            end
        end
    end

    initial begin
        int cyc;

        // Reset state
        repeat (3) tick();
        chk("rst_valid", int'(valid3), 0);
        chk("rst_from", int'(from3), 0);
        chk("rst_to", int'(to3), 0);
        chk("rst_disk", int'(disk3), 0);
        chk("rst_count", int'(count3), 0);
        chk("rst_busy", int'(busy3), 0);
        chk("rst_done", int'(done3), 0);
        rst = 1'b1;
        tick();

        // N=3 free-running: first move one cycle after start, then 7 back-to-back
        start_n3();
        chk("t1_first_valid", int'(valid3), 1);
        chk("t1_first_count", int'(count3), 0);
        chk("t1_first_busy", int'(busy3), 1);
        cyc = 0;
        while (!done3 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("t1_cycles_to_done", cyc, 7);
        chk("t1_done", int'(done3), 1);
        chk("t1_count", int'(count3), 7);
        chk("t1_busy", int'(busy3), 0);
        chk("t1_valid_after", int'(valid3), 0);

        // N=2 (label swap) and N=1 in parallel
        push2();
        push1();
        start2 = 1'b1;
        start1 = 1'b1;
        tick();
        start2 = 1'b0;
        start1 = 1'b0;
        cyc = 0;
        while (!(done2 && done1) && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("t2_done2", int'(done2), 1);
        chk("t2_count2", int'(count2), 3);
        chk("t2_busy2", int'(busy2), 0);
        chk("t2_done1", int'(done1), 1);
        chk("t2_count1", int'(count1), 1);

        // Restart from DONE, then stall move 4 for three cycles (start ignored)
        start_n3();
        chk("t3_restart_count", int'(count3), 0);
        chk("t3_restart_done", int'(done3), 0);
        chk("t3_restart_valid", int'(valid3), 1);
        wait_count3(3, "t3_reach_move4");
        ready3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) start3 = 1'b1;
            tick();
            start3 = 1'b0;
            chk("t3_stall_valid", int'(valid3), 1);
            chk("t3_stall_from", int'(from3), 0);
            chk("t3_stall_to", int'(to3), 2);
            chk("t3_stall_disk", int'(disk3), 3);
            chk("t3_stall_count", int'(count3), 3);
        end
        ready3 = 1'b1;
        tick();
        chk("t3_next_from", int'(from3), 1);
        chk("t3_next_to", int'(to3), 0);
        chk("t3_next_count", int'(count3), 4);
        wait_count3(7, "t3_finish");
        tick();
        chk("t3_done", int'(done3), 1);

        // Pause raised while move 2 is presented and not yet accepted
        start_n3();
        wait_count3(1, "t4_reach_move2");
        ready3 = 1'b0;
        pause3 = 1'b1;
        tick();
        chk("t4_hold_valid", int'(valid3), 1);
        chk("t4_hold_to", int'(to3), 1);
        ready3 = 1'b1;
        tick();
        chk("t4_paused_valid", int'(valid3), 0);
        chk("t4_paused_busy", int'(busy3), 1);
        chk("t4_paused_count", int'(count3), 2);
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("t4_start_ignored_valid", int'(valid3), 0);
        chk("t4_start_ignored_count", int'(count3), 2);
        pause3 = 1'b0;
        tick();
        chk("t4_resume_valid", int'(valid3), 1);
        chk("t4_resume_from", int'(from3), 2);
        chk("t4_resume_to", int'(to3), 1);
        wait_count3(7, "t4_finish");

        // Reset while move 5 is presented, then replay from move 1
        start_n3();
        wait_count3(4, "t5_reach_move5");
        rst = 1'b0;
        tick();
        chk("t5_rst_valid", int'(valid3), 0);
        chk("t5_rst_from", int'(from3), 0);
        chk("t5_rst_to", int'(to3), 0);
        chk("t5_rst_disk", int'(disk3), 0);
        chk("t5_rst_count", int'(count3), 0);
        chk("t5_rst_busy", int'(busy3), 0);
        rst = 1'b1;
        q3.delete();
        tick();
        start_n3();
        chk("t5_replay_valid", int'(valid3), 1);
        chk("t5_replay_from", int'(from3), 0);
        chk("t5_replay_to", int'(to3), 2);
        wait_count3(7, "t5_finish");
        tick();

        chk("q3_drained", q3.size(), 0);
        chk("q2_drained", q2.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hanoi_move_sequencer.md
Name: hanoi_move_sequencer

Overview:
- Autonomous solver/controller for the Towers of Hanoi game datapath.
- After a start pulse, issues the optimal 2^N−1 move sequence as from_rod/to_rod pairs over a valid/ready handshake.
- Moves the whole tower from rod 0 to rod 2.
- Sits in front of the game-state block. Its from_rod/to_rod outputs drive that block's move inputs directly. A game-state block without backpressure ties move_ready=1.

Parameters:
- NUMBER_OF_RODS, 3, rod count; only 3 is supported, other values are a compile-time error.
- NUMBER_OF_DISKS, 3, tower height N; legal range 1..16.
- RODS_LOG2 (localparam), $clog2(NUMBER_OF_RODS), rod index width.
- CNT_W (localparam), NUMBER_OF_DISKS, move index/count width; holds 2^N−1.
- DISK_W (localparam), $clog2(NUMBER_OF_DISKS+1), disk size width; holds 1..N.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
- start  input  1  begin a solve; sampled only in IDLE or DONE.
- pause  input  1  hold off issuing further moves.
- move_ready  input  1  datapath accepts the current move this cycle.
- move_valid  output  1  from_rod/to_rod/disk_id hold a move.
- from_rod  output  RODS_LOG2  source rod of the current move.
- to_rod  output  RODS_LOG2  destination rod of the current move.
- disk_id  output  DISK_W  size of the disk moved, 1 = smallest.
- move_count  output  CNT_W  number of moves accepted since the last start.
- busy  output  1  high in MOVE or PAUSED.
- done  output  1  high in DONE.

Behaviour:
- All outputs are registered.
- Reset (rst=0): state=IDLE; move_valid=0, from_rod=0, to_rod=0, disk_id=0, move_count=0, busy=0, done=0; internal index k=0.
- Reset wins over every other input in the same cycle, including mid-solve. The outputs never show a partial move after reset.

Move generation, index k = 1..2^N−1 (CNT_W-bit unsigned):
- raw_from = (k & (k−1)) mod 3.
- raw_to = ((k | (k−1)) + 1) mod 3. The +1 is computed at CNT_W+1 bits, so no overflow at k=2^N−1.
- disk_id = (count of trailing zeros of k) + 1.
- If N is even, swap rod labels 1 and 2 on both outputs. The final tower then always lands on rod 2.
- mod 3 is combinational on the registered k. The output registers load the move for k_next.

States:
- IDLE:
  - start=1 -> MOVE; k=1; move 1 loaded; move_valid=1 on the next cycle (1-cycle latency); move_count=0; busy=1.
- MOVE:
  - move_valid=1.
  - Handshake occurs when move_valid & move_ready: move_count+1.
  - Handshake with k = 2^N−1 -> DONE; move_valid=0; done=1 next cycle.
  - Handshake with pause=1 -> PAUSED; k advances; move_valid=0.
  - Handshake with pause=0 -> k+1; next move presented the next cycle. Back-to-back accepts give one move per clock.
  - No handshake: all move outputs held stable. move_valid never drops without a handshake, even if pause rises.
- PAUSED:
  - move_valid=0, busy=1.
  - pause=0 -> MOVE with the already-loaded move k.
  - start is ignored.
- DONE:
  - done=1, busy=0, move_count holds 2^N−1.
  - start=1 -> restart exactly as from IDLE; done clears the next cycle. The integrator must reset the game datapath before restarting.
- start in MOVE or PAUSED is ignored.
- N=1: a single move 0->2, disk 1, then DONE.

Test Plan:
- N=3, move_ready=1, start pulse:
  - Moves on 7 consecutive cycles from cycle+1: (0,2),(0,1),(2,1),(0,2),(1,0),(1,2),(0,2).
  - disk_id 1,2,1,3,1,2,1.
  - Then done=1, move_count=7, busy=0.
- N=2: moves (0,1),(0,2),(1,2) with disk_id 1,2,1 (label swap active); done with move_count=3.
- N=3, move_ready=0 for 3 cycles while move 4 is presented:
  - move_valid stays 1, outputs stay (0,2), disk 3, move_count stays 3.
  - Accept on the 4th cycle -> (1,0) next.
- pause raised while move 2 is presented and unaccepted:
  - Move 2 is still accepted.
  - Then move_valid=0 and busy=1 until pause drops.
  - Then move 3 (2,1) is presented.
- rst=0 during move 5 -> next cycle all outputs 0, state IDLE. A later start replays from move 1 (0,2).
- start during MOVE ignored, with no sequence change. start in DONE restarts with move_count=0 and move 1 (0,2) presented the next cycle.
